// File: rtl/descrambler.sv
// ---------------------------------------------------------------------------
// descrambler
//
// Receive-side lane descrambler. It sits after the per-lane 8b/10b decoder
// and recovers the original data symbols by XORing a keystream from a 16-bit
// Galois LFSR, G(X) = X^16 + X^5 + X^4 + X^3 + 1. This LFSR runs in lockstep
// with the far-end scrambler:
//   COM (K28.5, 8'hBC) : passed through unchanged, LFSR reloaded with LFSR_SEED
//   SKP (K28.0, 8'h1C) : passed through unchanged, LFSR frozen
//   other K            : passed through unchanged, LFSR advances 8 steps
//   D                  : data ^ keystream (or raw when scrambling is disabled),
//                        LFSR advances 8 steps in both cases
// The output is a one-deep registered valid/ready stage.
//
// Optional feature macro: DESCRAMBLER_SYNC_GATE_EN
//   defined     : the block starts UNSYNC and drops every symbol until the
//                 first COM is accepted; synced_o reflects the state.
//   not defined : the block is SYNC from reset and processes every symbol
//                 starting from the LFSR_SEED state; synced_o is always 1.
//
// Parameters:
//   DATA_WIDTH  symbol width (only 8 is supported)
//   LFSR_SEED   LFSR value loaded on reset and on every COM
//
// Ports:
//   clk_i                clock
//   rst_i                synchronous, active-low reset
//   data_i               decoded symbol (bit 0 first on the wire)
//   data_k_i             symbol is a K character
//   data_valid_i         input symbol present
//   descrambler_ready_o  input accepted when data_valid_i && descrambler_ready_o
//   scramble_disable_i   pass data symbols through unmodified
//   data_o               descrambled symbol
//   data_k_o             K flag registered alongside data_o
//   data_valid_o         output symbol present
//   data_ready_i         downstream takes the output when data_valid_o && data_ready_i
//   synced_o             LFSR aligned (a COM has been seen since reset)
// ---------------------------------------------------------------------------
module descrambler #(
  parameter int          DATA_WIDTH = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hFFFF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_k_i,
  input  logic                  data_valid_i,
  output logic                  descrambler_ready_o,
  input  logic                  scramble_disable_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_k_o,
  output logic                  data_valid_o,
  input  logic                  data_ready_i,
  output logic                  synced_o
);

  // The ordered-set symbol values and the 8-step unroll are specific to
  // 8-bit symbols.
  generate
    if (DATA_WIDTH != 8) begin : g_width_check
      $error("descrambler: only DATA_WIDTH == 8 is supported");
    end
  endgenerate

  localparam logic [DATA_WIDTH-1:0] COM_SYM  = DATA_WIDTH'(8'hBC);
  localparam logic [DATA_WIDTH-1:0] SKP_SYM  = DATA_WIDTH'(8'h1C);
  localparam logic [15:0]           LFSR_TAP = 16'h0039;

  typedef enum logic {
    UNSYNC = 1'b0,
    SYNC   = 1'b1
  } sync_e;

  typedef struct packed {
    logic [7:0]  ks;    // keystream byte, bit i produced by step i
    logic [15:0] lfsr;  // LFSR state after eight steps
  } adv_t;

  // Eight serial Galois steps collapsed into one combinational function.
  // Each step emits lfsr[15] as the next keystream bit (LSB first, matching
  // wire order) and then shifts, folding the tap mask in when the MSB was set.
  function automatic adv_t lfsr_adv8(input logic [15:0] state);
    adv_t        r;
    logic [15:0] l;
    l    = state;
    r.ks = '0;
    for (int i = 0; i < 8; i++) begin
      r.ks[i] = l[15];
      l       = {l[14:0], 1'b0} ^ (l[15] ? LFSR_TAP : 16'h0000);
    end
    r.lfsr = l;
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [15:0]           lfsr_q, lfsr_d;
  sync_e                 sync_q, sync_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  k_q, k_d;
  logic                  valid_q, valid_d;

  // -------------------------------------------------------------------------
  // Input classification and handshake
  // -------------------------------------------------------------------------
  logic accept;
  logic is_com;
  logic is_skp;
  adv_t adv;

  assign descrambler_ready_o = !valid_q || data_ready_i;
  assign accept              = data_valid_i && descrambler_ready_o;
  assign is_com              = data_k_i && (data_i == COM_SYM);
  assign is_skp              = data_k_i && (data_i == SKP_SYM);
  assign adv                 = lfsr_adv8(lfsr_q);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    lfsr_d  = lfsr_q;
    sync_d  = sync_q;
    data_d  = data_q;
    k_d     = k_q;
    // A presented symbol survives unless the downstream takes it this cycle.
    valid_d = valid_q && !data_ready_i;

    if (accept) begin
      if (is_com) begin
        // The seed load replaces the advance outright; the symbol after a COM
        // always starts from LFSR_SEED.
        lfsr_d  = LFSR_SEED;
        sync_d  = SYNC;
        data_d  = data_i;
        k_d     = 1'b1;
        valid_d = 1'b1;
      end else if (sync_q == SYNC) begin
        data_d  = data_i;
        k_d     = data_k_i;
        valid_d = 1'b1;
        if (!is_skp) begin
          lfsr_d = adv.lfsr;
          // The LFSR keeps running while scrambling is disabled so both ends
          // stay aligned when it is re-enabled.
          if (!data_k_i && !scramble_disable_i) begin
            data_d = data_i ^ DATA_WIDTH'(adv.ks);
          end
        end
      end
      // Otherwise UNSYNC: the symbol is consumed and dropped, LFSR untouched.
    end

`ifndef DESCRAMBLER_SYNC_GATE_EN
    sync_d = SYNC;
`endif
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lfsr_q  <= LFSR_SEED;
`ifdef DESCRAMBLER_SYNC_GATE_EN
      sync_q  <= UNSYNC;
`else
      sync_q  <= SYNC;
`endif
      data_q  <= '0;
      k_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      sync_q  <= sync_d;
      data_q  <= data_d;
      k_q     <= k_d;
      valid_q <= valid_d;
    end
  end

  assign data_o       = data_q;
  assign data_k_o     = k_q;
  assign data_valid_o = valid_q;
  assign synced_o     = (sync_q == SYNC);

endmodule
